// File: rtl/bcd_time_counter_pkg.sv
// Shared constants and helpers for the BCD time-of-day counter.
// Field limits are two-digit BCD values; set_sel encodings select the edited field.
package bcd_time_counter_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam logic [1:0] SEL_SEC  = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b01;
  localparam logic [1:0] SEL_HOUR = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  function automatic logic bcd_digit_valid(input logic [3:0] digit, input logic [3:0] max_digit);
    return digit <= max_digit;
  endfunction

  // Packing is {hT,hO,mT,mO,sT,sO}; hour ones limit tightens to 3 when hT is 2.
  function automatic logic bcd_time_valid(input logic [23:0] t);
    logic [3:0] ho_max;
    ho_max = (t[23:20] == 4'd2) ? 4'd3 : 4'd9;
    return bcd_digit_valid(t[23:20], 4'd2) && bcd_digit_valid(t[19:16], ho_max) &&
           bcd_digit_valid(t[15:12], 4'd5) && bcd_digit_valid(t[11:8], 4'd9) &&
           bcd_digit_valid(t[7:4], 4'd5)   && bcd_digit_valid(t[3:0], 4'd9);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD field counting 00..MAX with wrap in both directions.
// wrap flags an increment that takes the field from MAX back to 00.
module bcd_mod_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] value,
  output logic [7:0] q,
  output logic       wrap
);

  logic [7:0] q_q, q_d;
  logic       up, down;

  assign up   = inc & ~dec;
  assign down = dec & ~inc;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = value;
    end else if (up) begin
      if (q_q == MAX) begin
        q_d = 8'h00;
      end else if (q_q[3:0] == 4'd9) begin
        q_d = {q_q[7:4] + 4'd1, 4'd0};
      end else begin
        q_d = {q_q[7:4], q_q[3:0] + 4'd1};
      end
    end else if (down) begin
      if (q_q == 8'h00) begin
        q_d = MAX;
      end else if (q_q[3:0] == 4'd0) begin
        q_d = {q_q[7:4] - 4'd1, 4'd9};
      end else begin
        q_d = {q_q[7:4], q_q[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign wrap = up & ~load & (q_q == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour BCD time-of-day counter with 1 Hz prescaler, manual field set and validated load.
// Chime/day pulses and load_err are registered one-cycle strobes.
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        set_mode,
  input  logic [1:0]  set_sel,
  input  logic        inc,
  input  logic        dec,
  input  logic        load,
  input  logic [23:0] load_val,
  output logic [23:0] time_bcd,
  output logic        chime,
  output logic        day_pulse,
  output logic        load_err
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            chime_q, day_q, err_q;
  logic            tick, load_ok, load_acc;
  logic            sel_sec, sel_min, sel_hour;
  logic            sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
  logic            sec_wrap, min_wrap, hour_wrap;
  logic [7:0]      sec_q, min_q, hour_q;

  assign tick     = en & ~set_mode & (cnt_q == CntMax);
  assign load_ok  = bcd_time_valid(load_val);
  assign load_acc = load & load_ok;

  assign sel_sec  = (set_sel == SEL_SEC);
  assign sel_min  = (set_sel == SEL_MIN);
  assign sel_hour = (set_sel == SEL_HOUR);

  // Any load, accepted or not, freezes the fields for this cycle.
  assign sec_inc  = ~load & (set_mode ? (inc & sel_sec)  : tick);
  assign min_inc  = ~load & (set_mode ? (inc & sel_min)  : (tick & sec_wrap));
  assign hour_inc = ~load & (set_mode ? (inc & sel_hour) : (tick & sec_wrap & min_wrap));
  assign sec_dec  = ~load & set_mode & dec & sel_sec;
  assign min_dec  = ~load & set_mode & dec & sel_min;
  assign hour_dec = ~load & set_mode & dec & sel_hour;

  always_comb begin
    cnt_d = cnt_q;
    if (load_acc || set_mode) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      chime_q <= 1'b0;
      day_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      chime_q <= tick & ~load & sec_wrap & min_wrap;
      day_q   <= tick & ~load & sec_wrap & min_wrap & hour_wrap;
      err_q   <= load & ~load_ok;
    end
  end

  bcd_mod_counter #(
    .MAX (SEC_MAX)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .dec   (sec_dec),
    .load  (load_acc),
    .value (load_val[7:0]),
    .q     (sec_q),
    .wrap  (sec_wrap)
  );

  bcd_mod_counter #(
    .MAX (MIN_MAX)
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .dec   (min_dec),
    .load  (load_acc),
    .value (load_val[15:8]),
    .q     (min_q),
    .wrap  (min_wrap)
  );

  bcd_mod_counter #(
    .MAX (HOUR_MAX)
  ) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .dec   (hour_dec),
    .load  (load_acc),
    .value (load_val[23:16]),
    .q     (hour_q),
    .wrap  (hour_wrap)
  );

  assign time_bcd  = {hour_q, min_q, sec_q};
  assign chime     = chime_q;
  assign day_pulse = day_q;
  assign load_err  = err_q;

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Upstream source stage for the 24-bit display select multiplexer. Produces a packed BCD time-of-day value hh:mm:ss as 6 digits × 4 bits, which is one of that mux's eight inputs.
- Contains an internal 1 Hz prescaler, a 24-hour rollover chain, a manual set mode (increment/decrement one field), and a validated parallel load.
- Emits one-cycle pulses on hourly chime and day rollover for downstream alarm/calendar logic.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick; legal range ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  count enable; 0 freezes the prescaler and time.
- set_mode  in  1  1 = manual set; normal counting suspended.
- set_sel  in  2  field select: 00 sec, 01 min, 10 hour, 11 none.
- inc  in  1  single-cycle increment strobe for the selected field.
- dec  in  1  single-cycle decrement strobe for the selected field.
- load  in  1  parallel-load strobe.
- load_val  in  24  BCD {hT,hO,mT,mO,sT,sO}.
- time_bcd  out  24  current time, same packing as load_val; registered.
- chime  out  1  one-cycle pulse on each hh:59:59 -> (hh+1):00:00 rollover.
- day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, rst_n=0):
  - time_bcd = 24'h000000; prescaler = 0; chime, day_pulse, load_err = 0.
  - Takes effect immediately, including mid-set or mid-load.
- Prescaler counts 0..TICK_DIV-1 while en=1 and set_mode=0. It holds while en=0 and clears to 0 while set_mode=1.
- Tick: the edge at which prescaler == TICK_DIV-1 with en=1 and set_mode=0. At that edge the prescaler goes to 0 and seconds advance. time_bcd reflects the new value in the following cycle, with no extra pipeline delay.
- Rollover chain:
  - sO 9->0 carries to sT; seconds 59->00 carries to minutes.
  - minutes 59->00 carries to hours.
  - hours 23->00; hour ones digit wraps 9->0 below 20 and 3->0 at 23.
- chime is asserted for the cycle after each tick that takes mm:ss 59:59 -> 00:00.
- day_pulse is asserted for the cycle after the tick that takes 23:59:59 -> 00:00:00. chime is also asserted in that same cycle.
- Set mode (set_mode=1):
  - inc/dec modify only the field selected by set_sel, with modular wrap inside that field and no carry into other fields.
  - Ranges: sec and min 00..59, hour 00..23. Examples: inc at 59 -> 00; dec at 00 -> 59 (hour: 23).
  - inc and dec in the same cycle: no change.
  - set_sel=11: inc/dec ignored.
  - chime and day_pulse are never asserted by manual edits.
  - inc/dec are ignored when set_mode=0.
- Leaving set mode: prescaler starts from 0, so the first tick comes TICK_DIV cycles after set_mode falls.
- Load:
  - Accepted in any mode when every digit is valid: hT ≤ 2; hT=2 requires hO ≤ 3, otherwise hO ≤ 9; mT, sT ≤ 5; mO, sO ≤ 9.
  - Accepted load: time_bcd = load_val next cycle, prescaler cleared.
  - Rejected load: time unchanged, prescaler unaffected, load_err pulsed one cycle.
- Priority within a cycle: load > set-mode inc/dec > tick. A load coinciding with a tick discards the tick; no chime or day_pulse is generated.
- en=0 does not block load, nor set-mode inc/dec.
- All outputs come from registers; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package:
  - constants SEC_MAX = 8'h59, MIN_MAX = 8'h59, HOUR_MAX = 8'h23;
  - set_sel encodings SEL_SEC / SEL_MIN / SEL_HOUR / SEL_NONE;
  - a BCD-digit-valid function.
- One natural sub-module: bcd_mod_counter, a two-digit BCD field with a MAX parameter.
  - Inputs: inc, dec, load, value.
  - Output: wrap flag.
  - Instantiated 3× (sec, min, hour) and chained through the wrap flags for tick carries.
- The prescaler and load validation live in the top level.

Test Plan:
- Reset then en=1, TICK_DIV=4: after 4 edges time_bcd=24'h000001; after 40 edges 24'h000010. Assert rst_n low mid-count -> 24'h000000 immediately, without waiting for a clock edge.
- load 24'h235958 with TICK_DIV=4, en=1: after 4 edges 24'h235959; after 8 edges 24'h000000 with chime=1 and day_pulse=1 for exactly one cycle.
- load 24'h125959 -> next tick gives 24'h130000, chime=1, day_pulse=0. Drop en for 10 cycles mid-count -> value and prescaler frozen.
- set_mode=1, set_sel=01 at 24'h105900: inc -> 24'h100000 (no hour carry). set_sel=10 at hour 00: dec -> 24'h230000. inc+dec together -> unchanged. set_sel=11: inc -> unchanged.
- Invalid loads 24'h240000, 24'h006000, 24'h00000A -> time unchanged, load_err one cycle each. Valid load on the same cycle as a tick -> load value wins, no tick applied.
- Release set_mode at prescaler-relevant time -> first increment occurs exactly TICK_DIV cycles after release.
